da2_update_scheduler: RTL and testbench
=======================================

Name: da2_update_scheduler

Overview:
- Sequences the dual-channel Pmod DA2 serial interface and shares it between two requesters (A and B).
- Holds a shadow copy of value and mode for each DAC channel and arbitrates writes into it round-robin.
- Presents stable value0/value1/chmode0/chmode1 words and issues a one-cycle update pulse whenever the shadow changes.
- Tracks transfer completion through the interface's busy indication (SCLK_en), with optional periodic refresh and a start timeout.

Parameters:
- REFRESH_CYCLES, 0: clk cycles of idle after which an unchanged frame is re-sent; 0 disables refresh.
- START_TIMEOUT, 15: clk cycles allowed between the update pulse and dac_busy rising before the transfer is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- a_valid  in  1  requester A has a write.
- a_ch  in  1  A target channel (0/1).
- a_mode  in  2  A channel mode: 00 on, 01 1k, 10 100k, 11 Hi-Z.
- a_value  in  12  A code.
- a_ready  out  1  A write accepted this cycle.
- b_valid, b_ch, b_mode, b_value, b_ready  same as A, for requester B.
- dac_busy  in  1  interface busy (SCLK_en).
- update  out  1  one-cycle pulse to the interface.
- value0, value1  out  12  active codes.
- chmode0, chmode1  out  2  active modes.
- busy  out  1  transfer in flight (state != IDLE).
- timeout_err  out  1  one-cycle pulse on start timeout.

Behaviour:
- Reset values:
  - update=0, a_ready=b_ready=0, busy=0, timeout_err=0.
  - value0=value1=0, chmode0=chmode1=2'b11 (Hi-Z).
  - Shadow registers equal to the active registers; dirty=0; rr_ptr=A; state=IDLE.
- Accept (any state, at most one per cycle):
  - Only one valid: grant it.
  - Both valid: grant the side at rr_ptr, then flip rr_ptr to the other side.
  - x_ready is combinational: x_ready = x_valid & granted.
  - On accept, shadow[ch] <= {mode, value} and dirty <= 1.
- States:
  - IDLE:
    - If dirty, or refresh counter reached REFRESH_CYCLES-1 (when REFRESH_CYCLES != 0), go to ISSUE.
    - Refresh counter counts clk in IDLE and clears on leaving IDLE.
  - ISSUE (1 cycle):
    - Copy both shadows to the active outputs and clear dirty.
    - Drive update=1; go to WAIT_START.
    - An accept in the same cycle writes the shadow and sets dirty again; set wins over clear.
  - WAIT_START:
    - Wait for dac_busy=1, then go to WAIT_DONE.
    - Cycle counter reaching START_TIMEOUT: pulse timeout_err, go to IDLE. dirty stays as is; no retry forced.
  - WAIT_DONE: wait for dac_busy=0, then go to IDLE.
- Latency: accept at cycle N (in IDLE) -> ISSUE at N+1 -> update high at N+1, active outputs change at N+2 edge.
  - Correction: outputs are registered in ISSUE, so they are visible from N+2 and update is registered high during N+2.
  - Both update and the outputs are registers; update asserts on the same cycle the new outputs appear.
- Active outputs never change outside the ISSUE transition, so the interface sees stable data while SYNC loads.
- Writes arriving during WAIT_* are coalesced: the last write per channel wins, and only one follow-up frame is sent.
- update is never asserted while state != IDLE-derived ISSUE. This guarantees no pulse while the interface is busy.
- dac_busy already high in IDLE (stale) is ignored.
- Asynchronous rst mid-transfer: return to reset values immediately. Shadow data is lost and outputs go to Hi-Z mode.

Decomposition:
- Shared package da2_pkg:
  - Mode constants MODE_ON=2'b00, MODE_1K=2'b01, MODE_100K=2'b10, MODE_HIZ=2'b11.
  - State enum {IDLE, ISSUE, WAIT_START, WAIT_DONE}.
  - Frame width constant 12.
- One sub-module: rr_arb2 (2-way round-robin grant with pointer register, same clk/rst).

Test Plan:
- Reset, then A writes ch0 0x800 mode 00 -> a_ready=1 for one cycle; update pulse 2 cycles later; value0=0x800, chmode0=00; value1=0, chmode1=11.
- A (ch0 0x111) and B (ch1 0x222) valid together for 2 cycles -> A granted first, B second. Both shadows set; a single update with value0=0x111, value1=0x222 if both arrive before ISSUE.
- During WAIT_DONE, B writes ch1 0x0AA then 0x0BB -> no update until dac_busy falls, then exactly one update with value1=0x0BB.
- Model never raises dac_busy, START_TIMEOUT=15 -> timeout_err pulses 15 cycles after update; state returns to IDLE; busy=0.
- REFRESH_CYCLES=100, no writes -> update every transfer+100 idle cycles with unchanged outputs. REFRESH_CYCLES=0 -> no update.
- rst asserted while dac_busy=1 in WAIT_DONE -> busy=0, update=0, chmode0/1=11 immediately; the next write restarts normally.

Source files
------------

// File: rtl/da2_pkg.sv
// Shared types and constants for the Pmod DA2 update scheduler.
package da2_pkg;
  localparam int unsigned FRAME_W = 12;

  localparam logic [1:0] MODE_ON   = 2'b00;
  localparam logic [1:0] MODE_1K   = 2'b01;
  localparam logic [1:0] MODE_100K = 2'b10;
  localparam logic [1:0] MODE_HIZ  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  typedef struct packed {
    logic [1:0]         mode;
    logic [FRAME_W-1:0] value;
  } chan_t;

  localparam chan_t CHAN_RESET = '{mode: MODE_HIZ, value: '0};
endpackage

// File: rtl/da2_update_scheduler_if.sv
// Write-request handshake from one requester into the DA2 scheduler.
interface da2_req_if;
  import da2_pkg::*;

  logic               valid;
  logic               ch;
  logic [1:0]         mode;
  logic [FRAME_W-1:0] value;
  logic               ready;

  modport master (output valid, ch, mode, value, input ready);
  modport slave  (input valid, ch, mode, value, output ready);
endinterface

// File: rtl/da2_update_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both sides contend.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);
  logic ptr;  // 0 favours A, 1 favours B

  always_comb begin
    grant_a = req_a & (~req_b | ~ptr);
    grant_b = req_b & (~req_a | ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
    else if (req_a & req_b)
      ptr <= ~ptr;
  end
endmodule

// File: rtl/da2_update_scheduler.sv
// Shares the Pmod DA2 interface between two requesters via a shadowed, coalescing update FSM.
module da2_update_scheduler
  import da2_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 0,
  parameter int unsigned START_TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  da2_req_if.slave           a,
  da2_req_if.slave           b,
  input  logic               dac_busy,
  output logic               update,
  output logic [FRAME_W-1:0] value0,
  output logic [FRAME_W-1:0] value1,
  output logic [1:0]         chmode0,
  output logic [1:0]         chmode1,
  output logic               busy,
  output logic               timeout_err
);
  state_t      state;
  chan_t       shadow [2];
  logic        dirty;
  logic [31:0] cnt;

  logic        grant_a, grant_b, acc, acc_ch;
  chan_t       acc_word;
  logic        refresh_due;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a   (a.valid),
    .req_b   (b.valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign a.ready = a.valid & grant_a;
  assign b.ready = b.valid & grant_b;
  assign busy    = (state != IDLE);

  always_comb begin
    acc      = grant_a | grant_b;
    acc_ch   = grant_b ? b.ch : a.ch;
    acc_word = grant_b ? chan_t'({b.mode, b.value}) : chan_t'({a.mode, a.value});
    refresh_due = (REFRESH_CYCLES != 0) && (cnt == REFRESH_CYCLES - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow[0]   <= CHAN_RESET;
      shadow[1]   <= CHAN_RESET;
      dirty       <= 1'b0;
      cnt         <= '0;
      update      <= 1'b0;
      timeout_err <= 1'b0;
      value0      <= CHAN_RESET.value;
      value1      <= CHAN_RESET.value;
      chmode0     <= CHAN_RESET.mode;
      chmode1     <= CHAN_RESET.mode;
    end else begin
      update      <= 1'b0;
      timeout_err <= 1'b0;
      if (acc)
        shadow[acc_ch] <= acc_word;
      // A write landing in the ISSUE cycle is not in the copied frame, so it re-arms dirty.
      dirty <= acc | (dirty & (state != ISSUE));

      unique case (state)
        IDLE: begin
          if (dirty || acc || refresh_due) begin
            state <= ISSUE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ISSUE: begin
          value0  <= shadow[0].value;
          chmode0 <= shadow[0].mode;
          value1  <= shadow[1].value;
          chmode1 <= shadow[1].mode;
          update  <= 1'b1;
          state   <= WAIT_START;
          cnt     <= '0;
        end
        WAIT_START: begin
          if (dac_busy) begin
            state <= WAIT_DONE;
            cnt   <= '0;
          end else if (cnt == START_TIMEOUT - 1) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!dac_busy) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_da2_update_scheduler.sv
// Directed-vector bench for da2_update_scheduler: handshake, coalescing, timeout, refresh and reset.
module tb_da2_update_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_r = 1'b1;
  logic        dac_busy = 1'b0;
  logic        update, busy, timeout_err;
  logic [11:0] value0, value1;
  logic [1:0]  chmode0, chmode1;
  logic        update_r, busy_r, timeout_err_r;
  logic [11:0] value0_r, value1_r;
  logic [1:0]  chmode0_r, chmode1_r;

  int total = 0;
  int bad   = 0;

  da2_req_if ia ();
  da2_req_if ib ();
  da2_req_if ra ();
  da2_req_if rb ();

  always #5 clk = ~clk;

  da2_update_scheduler #(.REFRESH_CYCLES(0), .START_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .a(ia), .b(ib), .dac_busy(dac_busy),
    .update(update), .value0(value0), .value1(value1),
    .chmode0(chmode0), .chmode1(chmode1), .busy(busy), .timeout_err(timeout_err)
  );

  da2_update_scheduler #(.REFRESH_CYCLES(100), .START_TIMEOUT(15)) dut_r (
    .clk(clk), .rst(rst_r), .a(ra), .b(rb), .dac_busy(1'b0),
    .update(update_r), .value0(value0_r), .value1(value1_r),
    .chmode0(chmode0_r), .chmode1(chmode1_r), .busy(busy_r), .timeout_err(timeout_err_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic ach, input logic [1:0] am, input logic [11:0] aval,
                       input logic bv, input logic bch, input logic [1:0] bm, input logic [11:0] bval);
    ia.valid = av; ia.ch = ach; ia.mode = am; ia.value = aval;
    ib.valid = bv; ib.ch = bch; ib.mode = bm; ib.value = bval;
  endtask

  // Count negedges until update is seen, up to lim.
  task automatic wait_upd(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!update && n < lim);
    chk("upd_seen", update, 1);
  endtask

  int n, cnt_upd, early;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ra.valid = 0; ra.ch = 0; ra.mode = 0; ra.value = 0;
    rb.valid = 0; rb.ch = 0; rb.mode = 0; rb.value = 0;
    repeat (2) @(negedge clk);
    chk("rst_update", update, 0);
    chk("rst_busy", busy, 0);
    chk("rst_value0", value0, 0);
    chk("rst_chmode0", chmode0, 2'b11);
    chk("rst_chmode1", chmode1, 2'b11);
    rst = 1'b0;

    // Single write from A
    @(negedge clk);
    drive(1, 0, 2'b00, 12'h800, 0, 0, 0, 0);
    #1 chk("t1_a_ready", ia.ready, 1);
    chk("t1_b_ready", ib.ready, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t1_a_ready_drop", ia.ready, 0);
    chk("t1_issue_busy", busy, 1);
    chk("t1_issue_noupd", update, 0);
    @(negedge clk);
    chk("t1_update", update, 1);
    chk("t1_value0", value0, 12'h800);
    chk("t1_chmode0", chmode0, 2'b00);
    chk("t1_value1", value1, 0);
    chk("t1_chmode1", chmode1, 2'b11);
    dac_busy = 1'b1;
    @(negedge clk);
    chk("t1_pulse_once", update, 0);
    dac_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_back_idle", busy, 0);

    // A and B contend for two cycles: A first, then B (B lands in ISSUE -> follow-up frame)
    drive(1, 0, 2'b00, 12'h111, 1, 1, 2'b01, 12'h222);
    #1 chk("t2_a_first", ia.ready, 1);
    chk("t2_b_wait", ib.ready, 0);
    @(negedge clk);
    #1 chk("t2_a_second", ia.ready, 0);
    chk("t2_b_second", ib.ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_upd1", update, 1);
    chk("t2_upd1_v0", value0, 12'h111);
    chk("t2_upd1_v1", value1, 0);
    dac_busy = 1'b1;
    @(negedge clk);
    dac_busy = 1'b0;
    wait_upd(8, n);
    chk("t2_upd2_lat", n, 3);
    chk("t2_upd2_v0", value0, 12'h111);
    chk("t2_upd2_v1", value1, 12'h222);
    chk("t2_upd2_m1", chmode1, 2'b01);

    // Writes during WAIT_DONE coalesce into one follow-up frame
    dac_busy = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 2'b00, 12'h0AA);
    #1 chk("t3_b_ready_aa", ib.ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 2'b00, 12'h0BB);
    #1 chk("t3_b_ready_bb", ib.ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cnt_upd = 0;
    repeat (4) begin
      @(negedge clk);
      cnt_upd += int'(update);
    end
    chk("t3_hold_noupd", cnt_upd, 0);
    chk("t3_hold_v1", value1, 12'h222);
    dac_busy = 1'b0;
    wait_upd(8, n);
    chk("t3_upd_lat", n, 3);
    chk("t3_value1", value1, 12'h0BB);
    chk("t3_chmode1", chmode1, 2'b00);

    // No dac_busy: timeout 15 cycles after the update pulse, then silence
    early = 0;
    cnt_upd = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i < 15) begin
        early += int'(timeout_err);
        cnt_upd += int'(update);
      end
    end
    chk("t4_no_early_err", early, 0);
    chk("t4_single_frame", cnt_upd, 0);
    chk("t4_timeout_err", timeout_err, 1);
    chk("t4_idle_busy", busy, 0);
    @(negedge clk);
    chk("t4_err_pulse", timeout_err, 0);
    cnt_upd = 0;
    repeat (10) begin
      @(negedge clk);
      cnt_upd += int'(update);
    end
    chk("t4_no_refresh", cnt_upd, 0);

    // Reset in WAIT_DONE, then a clean restart
    drive(1, 0, 2'b10, 12'h555, 0, 0, 0, 0);
    #1 chk("t5_a_ready", ia.ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wait_upd(4, n);
    chk("t5_upd_lat", n, 1);
    chk("t5_value0", value0, 12'h555);
    chk("t5_chmode0", chmode0, 2'b10);
    dac_busy = 1'b1;
    @(negedge clk);
    chk("t5_wait_done_busy", busy, 1);
    rst = 1'b1;
    #1 chk("t5_rst_busy", busy, 0);
    chk("t5_rst_update", update, 0);
    chk("t5_rst_chmode0", chmode0, 2'b11);
    chk("t5_rst_chmode1", chmode1, 2'b11);
    chk("t5_rst_value0", value0, 0);
    @(negedge clk);
    rst = 1'b0;
    dac_busy = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 2'b00, 12'h7FF);
    #1 chk("t5_b_ready", ib.ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wait_upd(4, n);
    chk("t5_restart_lat", n, 1);
    chk("t5_restart_v1", value1, 12'h7FF);
    chk("t5_restart_m1", chmode1, 2'b00);
    chk("t5_restart_m0", chmode0, 2'b11);

    // Refresh instance: 100 idle cycles -> ISSUE; no dac_busy so each transfer is ISSUE + 15 WAIT_START
    @(negedge clk);
    rst_r = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!update_r && n < 300);
    chk("t6_first_refresh", n, 101);
    chk("t6_v0", value0_r, 0);
    chk("t6_m0", chmode0_r, 2'b11);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!update_r && n < 300);
    chk("t6_refresh_period", n, 116);
    chk("t6_m1", chmode1_r, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
